// File: rtl/dbus_write_buffer_pkg.sv
// Shared types for the data-bus posted-write buffer: queued store entry and
// control FSM state encoding.
package dbus_write_buffer_pkg;

  // Entries carry the widest supported address; the top narrows it back to ADDR_WIDTH.
  localparam int unsigned WBUF_ADDR_MAX = 64;

  typedef logic [WBUF_ADDR_MAX-1:0] wbuf_addr_t;

  typedef struct packed {
    wbuf_addr_t  addr;
    logic [31:0] wrdata;
    logic [3:0]  be;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store queue with naturally wrapping head/tail pointers; DEPTH must
// be a power of two.
module wbuf_fifo
  import dbus_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wbuf_entry_t              push_data,
  input  logic                     pop,
  output wbuf_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wbuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dbus_write_buffer.sv
// Posted-write buffer: stores retire in order from a FIFO; a load waits for
// all older stores to retire and then issues one blocking read.
module dbus_write_buffer
  import dbus_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_valid,
  input  logic                    cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
  input  logic [31:0]             cpu_req_wrdata,
  input  logic [3:0]              cpu_req_be,
  output logic                    cpu_req_ready,
  output logic                    cpu_resp_valid,
  output logic [31:0]             cpu_resp_rddata,
  output logic                    mem_req_valid,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [31:0]             mem_req_wrdata,
  output logic [3:0]              mem_req_be,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [31:0]             mem_resp_rddata,
  output logic                    wbuf_empty,
  output logic [$clog2(DEPTH):0]  wbuf_count
);

  wbuf_state_e           state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  wbuf_entry_t           push_entry;
  wbuf_entry_t           head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  load_acc;

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (wbuf_count)
  );

  assign push_entry    = '{addr: wbuf_addr_t'(cpu_req_addr), wrdata: cpu_req_wrdata, be: cpu_req_be};
  assign cpu_req_ready = (state == IDLE) && (cpu_req_we ? !fifo_full : 1'b1);
  assign push          = cpu_req_valid && cpu_req_we && cpu_req_ready;
  assign load_acc      = cpu_req_valid && !cpu_req_we && (state == IDLE);
  assign wbuf_empty    = fifo_empty;

  // Request fields depend only on registered state and the FIFO head, so they
  // hold steady while the memory stalls.
  always_comb begin
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wrdata = '0;
    mem_req_be     = '0;
    pop            = 1'b0;
    if (state == RD_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = rd_addr;
      mem_req_be    = 4'hf;
    end else if ((state == IDLE || state == DRAIN) && !fifo_empty) begin
      mem_req_valid  = 1'b1;
      mem_req_we     = 1'b1;
      mem_req_addr   = ADDR_WIDTH'(head.addr);
      mem_req_wrdata = head.wrdata;
      mem_req_be     = head.be;
      pop            = mem_req_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rd_addr         <= '0;
      cpu_resp_valid  <= 1'b0;
      cpu_resp_rddata <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_acc) begin
            rd_addr <= cpu_req_addr;
            state   <= fifo_empty ? RD_REQ : DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) state <= RD_REQ;
        end
        RD_REQ: begin
          if (mem_req_ready) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_resp_valid) begin
            cpu_resp_valid  <= 1'b1;
            cpu_resp_rddata <= mem_resp_rddata;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_write_buffer.sv
// Directed and random stimulus for dbus_write_buffer, checked every cycle
// against a transaction-level model (store queue plus load progress).
module tb_dbus_write_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid;
  logic          cpu_req_we;
  logic [AW-1:0] cpu_req_addr;
  logic [31:0]   cpu_req_wrdata;
  logic [3:0]    cpu_req_be;
  logic          cpu_req_ready;
  logic          cpu_resp_valid;
  logic [31:0]   cpu_resp_rddata;
  logic          mem_req_valid;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_wrdata;
  logic [3:0]    mem_req_be;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_rddata;
  logic          wbuf_empty;
  logic [$clog2(DEPTH):0] wbuf_count;

  always #5 clk = ~clk;

  dbus_write_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_we      (cpu_req_we),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_wrdata  (cpu_req_wrdata),
    .cpu_req_be      (cpu_req_be),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_resp_valid  (cpu_resp_valid),
    .cpu_resp_rddata (cpu_resp_rddata),
    .mem_req_valid   (mem_req_valid),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wrdata  (mem_req_wrdata),
    .mem_req_be      (mem_req_be),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_rddata (mem_resp_rddata),
    .wbuf_empty      (wbuf_empty),
    .wbuf_count      (wbuf_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  // Model: pending stores, and load progress
  // (0 none, 1 waiting for older stores, 2 read on the port, 3 read outstanding).
  st_t         wq[$];
  int unsigned phase     = 0;
  logic [31:0] ld_addr   = '0;
  logic [31:0] resp_data = '0;
  logic        resp_due  = 1'b0;
  int unsigned max_cnt   = 0;
  logic        tog       = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic we,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic mrdy, input logic mrv, input logic [31:0] mrd,
                      output logic acc);
    logic        e_ready, e_mv, e_mwe, due;
    logic [31:0] e_ma, e_md;
    logic [3:0]  e_mbe;
    int unsigned sz, nphase;
    @(negedge clk);
    rst = r; cpu_req_valid = v; cpu_req_we = we; cpu_req_addr = a;
    cpu_req_wrdata = d; cpu_req_be = be;
    mem_req_ready = mrdy; mem_resp_valid = mrv; mem_resp_rddata = mrd;
    #1;
    sz      = wq.size();
    e_ready = (phase == 0) && (!we || sz < DEPTH);
    e_mv = 1'b0; e_mwe = 1'b0; e_ma = '0; e_md = '0; e_mbe = '0;
    if (phase == 2) begin
      e_mv = 1'b1; e_ma = ld_addr; e_mbe = 4'hf;
    end else if (phase <= 1 && sz != 0) begin
      e_mv = 1'b1; e_mwe = 1'b1; e_ma = wq[0].addr; e_md = wq[0].data; e_mbe = wq[0].be;
    end
    check("cpu_req_ready", cpu_req_ready, e_ready);
    check("mem_req_valid", mem_req_valid, e_mv);
    check("mem_req_we", mem_req_we, e_mwe);
    check("mem_req_addr", mem_req_addr, e_ma);
    check("mem_req_wrdata", mem_req_wrdata, e_md);
    check("mem_req_be", mem_req_be, e_mbe);
    check("cpu_resp_valid", cpu_resp_valid, resp_due);
    if (resp_due) check("cpu_resp_rddata", cpu_resp_rddata, resp_data);
    check("wbuf_count", wbuf_count, sz);
    check("wbuf_empty", wbuf_empty, sz == 0);
    if (wbuf_count > max_cnt) max_cnt = wbuf_count;
    acc = v && e_ready && !r;
    @(posedge clk);
    if (r) begin
      wq.delete();
      phase    = 0;
      resp_due = 1'b0;
    end else begin
      nphase = phase;
      due    = 1'b0;
      if (e_mv && mrdy) begin
        if (e_mwe) void'(wq.pop_front());
        else nphase = 3;
      end
      if (phase == 1 && sz == 0) nphase = 2;
      if (phase == 3 && mrv) begin
        due = 1'b1; resp_data = mrd; nphase = 0;
      end
      if (acc) begin
        if (we) wq.push_back('{a, d, be});
        else begin
          ld_addr = a;
          nphase  = (sz != 0) ? 1 : 2;
        end
      end
      phase    = nphase;
      resp_due = due;
    end
  endtask

  task automatic idle(input int unsigned n, input logic mrdy);
    logic acc;
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0, '0, mrdy, 1'b0, '0, acc);
  endtask

  task automatic store_until(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic mrdy, input logic tog_rdy, output int unsigned rejected);
    logic acc;
    rejected = 0;
    acc      = 1'b0;
    while (!acc && rejected < 64) begin
      tog = ~tog;
      step(1'b0, 1'b1, 1'b1, a, d, be, tog_rdy ? tog : mrdy, 1'b0, '0, acc);
      if (!acc) rejected++;
    end
    check("store_accepted", acc, 1'b1);
  endtask

  task automatic load_req(input logic [31:0] a, input logic mrdy);
    logic acc;
    step(1'b0, 1'b1, 1'b0, a, '0, '0, mrdy, 1'b0, '0, acc);
    check("load_accepted", acc, 1'b1);
  endtask

  // Memory side: accept the read, reply after 'delay' idle cycles; optionally
  // offer a store from the CPU while the load is outstanding.
  task automatic serve_read(input logic [31:0] data, input int unsigned delay, input logic poke);
    logic        acc;
    int unsigned n;
    n = 0;
    while (phase != 3 && n < 64) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
      n++;
    end
    check("read_issued_in_time", phase == 3, 1'b1);
    repeat (delay) step(1'b0, poke, 1'b1, 32'h4000, 32'h1, 4'hf, 1'b1, 1'b0, '0, acc);
    step(1'b0, poke, 1'b1, 32'h4000, 32'h1, 4'hf, 1'b1, 1'b1, data, acc);
    #1;
    check("load_resp", {cpu_resp_valid, cpu_resp_rddata}, {1'b1, data});
    idle(2, 1'b1);
  endtask

  initial begin
    int unsigned rej;
    logic        acc;
    rst = 1'b1; cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0;
    cpu_req_wrdata = '0; cpu_req_be = '0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_rddata = '0;
    repeat (2) @(posedge clk);
    idle(1, 1'b0);
    check("reset_rddata", cpu_resp_rddata, 32'h0);

    // Three stores streamed to an always-ready memory.
    max_cnt = 0;
    store_until(32'h100, 32'h11, 4'hf, 1'b1, 1'b0, rej);
    store_until(32'h104, 32'h22, 4'hf, 1'b1, 1'b0, rej);
    store_until(32'h108, 32'h33, 4'hf, 1'b1, 1'b0, rej);
    idle(3, 1'b1);
    check("three_store_peak", max_cnt, 1);

    // Store then load of the same address while memory stalls.
    store_until(32'h200, 32'hdeadbeef, 4'h3, 1'b0, 1'b0, rej);
    load_req(32'h200, 1'b0);
    idle(3, 1'b0);
    serve_read(32'h0bad0200, 1, 1'b0);

    // Fill to DEPTH, then one more that must wait for the first pop.
    for (int unsigned i = 0; i < DEPTH; i++)
      store_until(32'h1000 + 4 * i, 32'ha0 + i, 4'(i), 1'b0, 1'b0, rej);
    #1;
    check("full_count", wbuf_count, DEPTH);
    step(1'b0, 1'b1, 1'b1, 32'h1100, 32'h99, 4'h9, 1'b0, 1'b0, '0, acc);
    check("ninth_rejected", acc, 1'b0);
    store_until(32'h1100, 32'h99, 4'h9, 1'b1, 1'b0, rej);
    check("ninth_wait_cycles", rej, 1);
    idle(DEPTH + 2, 1'b1);

    // Pointer wrap with a toggling ready.
    max_cnt = 0;
    for (int unsigned i = 0; i < 20; i++)
      store_until(32'h3000 + 4 * i, $urandom, 4'($urandom), 1'b0, 1'b1, rej);
    idle(24, 1'b1);
    check("wrap_max_count", max_cnt <= DEPTH, 1'b1);

    // Load on an empty buffer, reply after three cycles, stores offered meanwhile.
    load_req(32'h500, 1'b1);
    serve_read(32'hcafef00d, 3, 1'b1);
    idle(DEPTH + 2, 1'b1);

    // Reset while draining four queued stores.
    for (int unsigned i = 0; i < 4; i++)
      store_until(32'h600 + 4 * i, 32'h60 + i, 4'hf, 1'b0, 1'b0, rej);
    load_req(32'h700, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, acc);
    #1;
    check("rst_count", wbuf_count, 0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_ready", cpu_req_ready, 1'b1);

    // Reset while the read is outstanding; a late response must be dropped.
    load_req(32'h800, 1'b1);
    idle(2, 1'b1);
    check("model_in_rd_wait", phase, 3);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, acc);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 32'h12345678, acc);
    #1;
    check("late_resp_ignored", cpu_resp_valid, 1'b0);
    check("late_resp_rddata", cpu_resp_rddata, 32'h0);
    idle(1, 1'b0);

    // Random traffic with occasional reset.
    for (int unsigned i = 0; i < 1500; i++) begin
      step(($urandom % 256) == 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
           $urandom & 32'hffff_fffc, $urandom, 4'($urandom),
           ($urandom % 3) != 0, (phase == 3) && ($urandom % 2 == 0), $urandom, acc);
    end
    idle(40, 1'b1);
    if (phase == 3) step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 32'h77, acc);
    idle(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
